// File: rtl/sd_spi_card.sv
// SD-card responder on the SPI link: oversamples SCLK/MOSI/CS, parses 6-byte
// command frames, answers R1/R3/R7 and streams CMD17 blocks from a byte source.
module sd_spi_card #(
    parameter int BLOCK_LEN  = 512,
    parameter int RESP_DELAY = 0,
    parameter int DATA_DELAY = 1,
    parameter int INIT_POLLS = 2,
    parameter int CHECK_CRC  = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic        CMD_STB,
    output logic [5:0]  CMD_IDX,
    output logic [31:0] CMD_ARG,
    output logic        IN_IDLE,
    output logic        BLK_REQ,
    output logic [31:0] BLK_ADDR,
    input  logic        BD_STB,
    input  logic [7:0]  BD_DATA,
    output logic        BD_ACK,
    output logic        UNDERRUN
);
    localparam int CW = $clog2(BLOCK_LEN + 1);

    typedef enum logic [2:0] {LISTEN, CMD, RESP, DDLY, DTOK, DDAT, DCRC} state_t;

    state_t        state_q, state_d;
    logic          sclk_m_q, sclk_s_q, sclk_p_q, mosi_m_q, mosi_s_q, cs_m_q, cs_s_q;
    logic [6:0]    rx_q, rx_d;
    logic [2:0]    bitcnt_q, bitcnt_d, fcnt_q, fcnt_d, rleft_q, rleft_d, rdly_q, rdly_d;
    logic [7:0]    tx_q, tx_d, hold_q, hold_d, poll_q, poll_d;
    logic [39:0]   frm_q, frm_d, rsp_q, rsp_d;
    logic          rdata_q, rdata_d, hfull_q, hfull_d, idle_q, idle_d, app_q, app_d;
    logic [3:0]    dcnt_q, dcnt_d;
    logic [CW-1:0] scnt_q, scnt_d, acc_q, acc_d;
    logic          blk_req_q, blk_req_d, cmd_stb_q, cmd_stb_d, und_q, und_d;
    logic [31:0]   blk_addr_q, blk_addr_d, cmd_arg_q, cmd_arg_d;
    logic [5:0]    cmd_idx_q, cmd_idx_d;

    logic        rise, fall, byte_ev, bd_ack, emit, e_data, nidle;
    logic [7:0]  rx_byte, illegal, pn;
    logic [39:0] e_buf;
    logic [2:0]  e_left, e_dly;
    logic [5:0]  idx;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_m_q <= 1'b0; sclk_s_q <= 1'b0; sclk_p_q <= 1'b0;
            mosi_m_q <= 1'b1; mosi_s_q <= 1'b1;
            cs_m_q   <= 1'b1; cs_s_q   <= 1'b1;
        end else begin
            sclk_m_q <= SCLK;     sclk_s_q <= sclk_m_q; sclk_p_q <= sclk_s_q;
            mosi_m_q <= MOSI;     mosi_s_q <= mosi_m_q;
            cs_m_q   <= CS;       cs_s_q   <= cs_m_q;
        end
    end

    assign rise    = ~cs_s_q & sclk_s_q & ~sclk_p_q;
    assign fall    = ~cs_s_q & ~sclk_s_q & sclk_p_q;
    assign byte_ev = rise & (bitcnt_q == 3'd7);
    assign rx_byte = {rx_q, mosi_s_q};
    assign idx     = frm_q[37:32];
    assign illegal = {5'b0, 1'b1, 1'b0, idle_q};
    assign pn      = poll_q + 8'd1;
    assign nidle   = idle_q & (pn != 8'(INIT_POLLS));
    assign bd_ack  = ~hfull_q & blk_req_q & BD_STB & (acc_q < CW'(BLOCK_LEN));

    always_comb begin
        state_d = state_q;   rx_d = rx_q;       bitcnt_d = bitcnt_q; tx_d = tx_q;
        frm_d = frm_q;       fcnt_d = fcnt_q;   rsp_d = rsp_q;       rleft_d = rleft_q;
        rdly_d = rdly_q;     rdata_d = rdata_q; dcnt_d = dcnt_q;     scnt_d = scnt_q;
        acc_d = acc_q;       hold_d = hold_q;   hfull_d = hfull_q;   idle_d = idle_q;
        app_d = app_q;       poll_d = poll_q;   blk_req_d = blk_req_q;
        blk_addr_d = blk_addr_q; cmd_idx_d = cmd_idx_q; cmd_arg_d = cmd_arg_q;
        cmd_stb_d = 1'b0;    und_d = 1'b0;
        emit = 1'b0; e_buf = rsp_q; e_left = rleft_q; e_dly = rdly_q; e_data = rdata_q;

        if (bd_ack) begin
            hold_d = BD_DATA; hfull_d = 1'b1; acc_d = acc_q + 1'b1;
        end
        if (rise) begin
            rx_d = rx_byte[6:0]; bitcnt_d = bitcnt_q + 3'd1;
        end
        if (fall && bitcnt_q != 3'd0) tx_d = {tx_q[6:0], 1'b1};

        if (byte_ev) begin
            tx_d = 8'hFF;
            case (state_q)
                LISTEN: if (rx_byte[7:6] == 2'b01) begin
                    frm_d = {32'h0, rx_byte}; fcnt_d = 3'd1; state_d = CMD;
                end
                CMD: if (fcnt_q != 3'd5) begin
                    frm_d = {frm_q[31:0], rx_byte}; fcnt_d = fcnt_q + 3'd1;
                end else begin
                    emit = 1'b1; e_dly = 3'(RESP_DELAY); e_data = 1'b0; e_left = 3'd1;
                    e_buf = {illegal, 32'h0};
                    app_d = 1'b0;
                    if (!rx_byte[0]) begin
                        e_buf = {illegal, 32'h0};
                    end else if (CHECK_CRC != 0 && (idx == 6'd0 || idx == 6'd8)
                                 && crc7(frm_q) != rx_byte[7:1]) begin
                        e_buf = {4'b0, 1'b1, 2'b0, idle_q, 32'h0};
                    end else begin
                        cmd_stb_d = 1'b1; cmd_idx_d = idx; cmd_arg_d = frm_q[31:0];
                        case (idx)
                            6'd0: begin
                                idle_d = 1'b1; poll_d = 8'd0; e_buf = {8'h01, 32'h0};
                            end
                            6'd8: begin
                                e_buf  = {7'b0, idle_q, 16'h0, 4'h0, frm_q[11:0]};
                                e_left = 3'd5;
                            end
                            6'd55: begin
                                e_buf = {7'b0, idle_q, 32'h0}; app_d = 1'b1;
                            end
                            6'd41: if (app_q) begin
                                poll_d = pn; idle_d = nidle; e_buf = {7'b0, nidle, 32'h0};
                            end
                            6'd58: begin
                                e_buf  = {7'b0, idle_q, (idle_q ? 8'h00 : 8'hC0), 24'hFF8000};
                                e_left = 3'd5;
                            end
                            6'd17: if (idle_q) begin
                                e_buf = {8'h05, 32'h0};
                            end else begin
                                e_buf = {8'h00, 32'h0}; e_data = 1'b1;
                                blk_addr_d = frm_q[31:0]; blk_req_d = 1'b1; acc_d = '0;
                            end
                            default: e_buf = {illegal, 32'h0};
                        endcase
                    end
                end
                RESP: emit = 1'b1;
                DDLY: begin
                    if (dcnt_q == 4'd1) state_d = DTOK;
                    else dcnt_d = dcnt_q - 4'd1;
                end
                DTOK: if (hfull_q) begin
                    tx_d = 8'hFE; scnt_d = '0; state_d = DDAT;
                end
                DDAT: begin
                    if (hfull_q) begin
                        tx_d = hold_q; hfull_d = 1'b0;
                    end else begin
                        tx_d = 8'h00; und_d = 1'b1;
                    end
                    scnt_d = scnt_q + 1'b1;
                    if (scnt_q == CW'(BLOCK_LEN - 1)) begin
                        scnt_d = '0; state_d = DCRC;
                    end
                end
                DCRC: begin
                    scnt_d = scnt_q + 1'b1;
                    if (scnt_q != '0) begin
                        state_d = LISTEN; blk_req_d = 1'b0; hfull_d = 1'b0;
                    end
                end
                default: state_d = LISTEN;
            endcase
        end

        // A response is either delayed by 0xFF fill or emits its next byte;
        // the last byte hands over to the data phase for a successful CMD17.
        if (emit) begin
            rdata_d = e_data;
            if (e_dly != 3'd0) begin
                tx_d = 8'hFF; rdly_d = e_dly - 3'd1; rsp_d = e_buf; rleft_d = e_left;
                state_d = RESP;
            end else begin
                tx_d = e_buf[39:32]; rsp_d = {e_buf[31:0], 8'hFF};
                rleft_d = e_left - 3'd1; rdly_d = 3'd0;
                if (e_left == 3'd1) begin
                    state_d = e_data ? DDLY : LISTEN; dcnt_d = 4'(DATA_DELAY);
                end else begin
                    state_d = RESP;
                end
            end
        end

        if (cs_s_q) begin
            bitcnt_d = 3'd0; tx_d = 8'hFF; state_d = LISTEN; blk_req_d = 1'b0; hfull_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= LISTEN; rx_q <= '0;    bitcnt_q <= '0;   tx_q <= 8'hFF;
            frm_q <= '0;       fcnt_q <= '0;  rsp_q <= '0;      rleft_q <= '0;
            rdly_q <= '0;      rdata_q <= 1'b0; dcnt_q <= '0;   scnt_q <= '0;
            acc_q <= '0;       hold_q <= '0;  hfull_q <= 1'b0;  idle_q <= 1'b1;
            app_q <= 1'b0;     poll_q <= '0;  blk_req_q <= 1'b0; blk_addr_q <= '0;
            cmd_idx_q <= '0;   cmd_arg_q <= '0; cmd_stb_q <= 1'b0; und_q <= 1'b0;
        end else begin
            state_q <= state_d; rx_q <= rx_d;     bitcnt_q <= bitcnt_d; tx_q <= tx_d;
            frm_q <= frm_d;     fcnt_q <= fcnt_d; rsp_q <= rsp_d;       rleft_q <= rleft_d;
            rdly_q <= rdly_d;   rdata_q <= rdata_d; dcnt_q <= dcnt_d;   scnt_q <= scnt_d;
            acc_q <= acc_d;     hold_q <= hold_d; hfull_q <= hfull_d;   idle_q <= idle_d;
            app_q <= app_d;     poll_q <= poll_d; blk_req_q <= blk_req_d; blk_addr_q <= blk_addr_d;
            cmd_idx_q <= cmd_idx_d; cmd_arg_q <= cmd_arg_d; cmd_stb_q <= cmd_stb_d; und_q <= und_d;
        end
    end

    assign MISO     = tx_q[7];
    assign CMD_STB  = cmd_stb_q;
    assign CMD_IDX  = cmd_idx_q;
    assign CMD_ARG  = cmd_arg_q;
    assign IN_IDLE  = idle_q;
    assign BLK_REQ  = blk_req_q;
    assign BLK_ADDR = blk_addr_q;
    assign BD_ACK   = bd_ack;
    assign UNDERRUN = und_q;
endmodule

// File: tb/tb_sd_spi_card.sv
// Directed bench for sd_spi_card: SPI host tasks, incrementing byte source,
// immediate-assertion checks against hand-computed responses.
module tb_sd_spi_card;
    logic        CLK = 1'b0, RST_N = 1'b0, SCLK = 1'b0, MOSI = 1'b1, CS = 1'b1;
    logic        MISO, CMD_STB, IN_IDLE, BLK_REQ, BD_STB, BD_ACK, UNDERRUN;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG, BLK_ADDR;
    logic [7:0]  BD_DATA;

    int vectors = 0, miscmp = 0;
    int stb_cnt = 0, ack_cnt = 0, und_cnt = 0, src_idx = 0, src_base = 0;
    logic src_en = 1'b0, stall = 1'b0;

    sd_spi_card dut (
        .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .MOSI(MOSI), .CS(CS), .MISO(MISO),
        .CMD_STB(CMD_STB), .CMD_IDX(CMD_IDX), .CMD_ARG(CMD_ARG), .IN_IDLE(IN_IDLE),
        .BLK_REQ(BLK_REQ), .BLK_ADDR(BLK_ADDR), .BD_STB(BD_STB), .BD_DATA(BD_DATA),
        .BD_ACK(BD_ACK), .UNDERRUN(UNDERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (CMD_STB)  stb_cnt++;
        if (UNDERRUN) und_cnt++;
        if (BD_ACK) begin
            ack_cnt++;
            src_idx++;
        end
    end

    assign BD_STB  = src_en && !(stall && (src_idx - src_base) == 100);
    assign BD_DATA = 8'(src_idx - src_base);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            repeat (4) @(negedge CLK);
            rx[i] = MISO;
            SCLK = 1'b1;
            repeat (4) @(negedge CLK);
            SCLK = 1'b0;
        end
    endtask

    task automatic cmd(input logic [7:0] b1, input logic [31:0] arg, input logic [7:0] crc);
        logic [7:0] r;
        xfer(b1, r); xfer(arg[31:24], r); xfer(arg[23:16], r);
        xfer(arg[15:8], r); xfer(arg[7:0], r); xfer(crc, r);
    endtask

    task automatic rd4(output logic [31:0] w);
        logic [7:0] r;
        for (int i = 0; i < 4; i++) begin
            xfer(8'hFF, r);
            w = {w[23:0], r};
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, {31'b0, MISO}, 32'd1);
        chk({tag, "_idle"}, {31'b0, IN_IDLE}, 32'd1);
        chk({tag, "_blkreq"}, {31'b0, BLK_REQ}, 32'd0);
        chk({tag, "_strobes"}, {29'b0, CMD_STB, BD_ACK, UNDERRUN}, 32'd0);
        chk({tag, "_idx_arg"}, CMD_ARG | {26'b0, CMD_IDX}, 32'd0);
        chk({tag, "_blkaddr"}, BLK_ADDR, 32'd0);
    endtask

    initial begin
        logic [7:0]  r;
        logic [31:0] w;
        int s0, a0, u0, errs, ffs, found;

        repeat (3) @(negedge CLK);
        chk_reset("rst");
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 10; i++) xfer(8'hFF, r);
        CS = 1'b0;
        repeat (4) @(negedge CLK);

        // CMD0
        s0 = stb_cnt;
        cmd(8'h40, 32'h0, 8'h95); xfer(8'hFF, r);
        chk("cmd0_r1", {24'b0, r}, 32'h01);
        chk("cmd0_stb", s0 - stb_cnt, 32'hFFFF_FFFF);
        chk("cmd0_idx", {26'b0, CMD_IDX}, 32'd0);
        chk("cmd0_idle", {31'b0, IN_IDLE}, 32'd1);

        // CMD8 good and bad CRC
        cmd(8'h48, 32'h1AA, 8'h87); xfer(8'hFF, r); rd4(w);
        chk("cmd8_r1", {24'b0, r}, 32'h01);
        chk("cmd8_r7", w, 32'h0000_01AA);
        chk("cmd8_arg", CMD_ARG, 32'h1AA);
        s0 = stb_cnt;
        cmd(8'h48, 32'h1AA, 8'h01); xfer(8'hFF, r);
        chk("cmd8_crc_r1", {24'b0, r}, 32'h09);
        chk("cmd8_crc_nostb", stb_cnt - s0, 32'd0);

        // init loop
        w = '0;
        for (int i = 0; i < 2; i++) begin
            cmd(8'h77, 32'h0, 8'h01);         xfer(8'hFF, r); w = {w[23:0], r};
            cmd(8'h69, 32'h4000_0000, 8'h01); xfer(8'hFF, r); w = {w[23:0], r};
        end
        chk("init_r1_seq", w, 32'h0101_0100);
        chk("init_idle", {31'b0, IN_IDLE}, 32'd0);
        cmd(8'h7A, 32'h0, 8'h01); xfer(8'hFF, r); rd4(w);
        chk("cmd58_r1", {24'b0, r}, 32'h00);
        chk("cmd58_ocr", w, 32'hC0FF_8000);

        // full block, source always ready
        src_base = src_idx; src_en = 1'b1; a0 = ack_cnt; u0 = und_cnt;
        cmd(8'h51, 32'h10, 8'h01); xfer(8'hFF, r);
        chk("blk1_r1", {24'b0, r}, 32'h00);
        chk("blk1_addr", BLK_ADDR, 32'h10);
        chk("blk1_req", {31'b0, BLK_REQ}, 32'd1);
        xfer(8'hFF, r); w = {24'b0, r};
        xfer(8'hFF, r); w = {w[23:0], r};
        chk("blk1_gap_token", w, 32'hFFFE);
        errs = 0;
        for (int k = 0; k < 512; k++) begin
            xfer(8'hFF, r);
            if (r !== 8'(k)) errs++;
        end
        chk("blk1_data_errs", errs, 32'd0);
        xfer(8'hFF, r); w = {24'b0, r};
        xfer(8'hFF, r); w = {w[23:0], r};
        chk("blk1_crc", w, 32'hFFFF);
        chk("blk1_acks", ack_cnt - a0, 32'd512);
        chk("blk1_underruns", und_cnt - u0, 32'd0);
        chk("blk1_req_done", {31'b0, BLK_REQ}, 32'd0);
        src_en = 1'b0;

        // late source, stall on byte 100, then CS abort
        src_base = src_idx; stall = 1'b1; u0 = und_cnt;
        cmd(8'h51, 32'h20, 8'h01); xfer(8'hFF, r);
        chk("blk2_r1", {24'b0, r}, 32'h00);
        ffs = 0; found = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(8'hFF, r);
            if (r === 8'hFF) ffs++;
        end
        src_en = 1'b1;
        for (int i = 0; i < 10 && found == 0; i++) begin
            xfer(8'hFF, r);
            if (r === 8'hFE) found = 1;
            else if (r === 8'hFF) ffs++;
        end
        chk("blk2_token_seen", found, 32'd1);
        chk("blk2_min_fill", {31'b0, ffs >= 4}, 32'd1);
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            xfer(8'hFF, r);
            if (r !== 8'(k)) errs++;
        end
        stall = 1'b0;
        chk("blk2_data_errs", errs, 32'd0);
        xfer(8'hFF, r);
        chk("blk2_underrun_byte", {24'b0, r}, 32'h00);
        errs = 0;
        for (int k = 101; k < 104; k++) begin
            xfer(8'hFF, r);
            if (r !== 8'(k - 1)) errs++;
        end
        chk("blk2_resume_errs", errs, 32'd0);
        chk("blk2_underruns", und_cnt - u0, 32'd1);
        CS = 1'b1;
        repeat (3) @(negedge CLK);
        chk("abort_miso", {31'b0, MISO}, 32'd1);
        chk("abort_req", {31'b0, BLK_REQ}, 32'd0);
        chk("abort_idle_kept", {31'b0, IN_IDLE}, 32'd0);
        repeat (4) @(negedge CLK);
        CS = 1'b0;
        repeat (4) @(negedge CLK);
        cmd(8'h7A, 32'h0, 8'h01); xfer(8'hFF, r); rd4(w);
        chk("abort_cmd58", {r, w[31:8]}, 32'h00C0_FF80);

        // reset in the middle of a block
        src_base = src_idx; src_en = 1'b1;
        cmd(8'h51, 32'h30, 8'h01);
        for (int i = 0; i < 23; i++) xfer(8'hFF, r);
        chk("blk3_req_mid", {31'b0, BLK_REQ}, 32'd1);
        #2 RST_N = 1'b0;
        #1 chk_reset("midrst");
        CS = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        CS = 1'b0;
        repeat (4) @(negedge CLK);
        cmd(8'h40, 32'h0, 8'h95); xfer(8'hFF, r);
        chk("post_cmd0_r1", {24'b0, r}, 32'h01);
        cmd(8'h51, 32'h0, 8'h01); xfer(8'hFF, r);
        chk("idle_cmd17_r1", {24'b0, r}, 32'h05);
        xfer(8'hFF, r);
        chk("idle_cmd17_req", {31'b0, BLK_REQ}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end
endmodule
